module_display_mux: RTL and testbench
=====================================

// Module: module_display_mux
// PURPOSE
//  Time-multiplexed 4-digit seven-segment driver downstream of the Hamming decoder/corrector.
//  Holds the last loaded corrected nibble, syndrome and error flag.
//  Keeps a saturating count of detected errors.
//  Scans all four digits on a common segment bus with anti-ghosting blanking.
// PARAMETERS
//  REFRESH_DIV     27000  clk cycles per digit slot (>= 2)
//  BLANK_CYCLES    16     cycles at start of each slot with all anodes off (< REFRESH_DIV)
//  SEG_ACTIVE_LOW  1      1: siete_seg_o inverted at output
//  AN_ACTIVE_LOW   1      1: anodo_o inverted at output
// PORTS
//  clk_i        in   1  system clock
//  rst_n_i      in   1  asynchronous active-low reset
//  dato_i       in   4  corrected data nibble
//  sindrome_i   in   3  syndrome, 0 = no error
//  error_i      in   1  error-detected flag
//  cargar_i     in   1  load strobe; samples dato_i/sindrome_i/error_i
//  clr_cnt_i    in   1  synchronous clear of error counter
//  anodo_o      out  4  digit enables, one-hot when lit
//  siete_seg_o  out  7  segments {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async, rst_n_i=0):
//   - div_cnt=0, digit_sel=0, holding regs=0, err_cnt=0.
//   - anodo_o and siete_seg_o driven to all-off (4'hF / 7'h7F with default polarity).
//  Load:
//   - cargar_i=1 at edge N -> dato_r/sind_r/err_r take the inputs at edge N.
//   - The active digit reflects the new value from edge N+1 (1-cycle output register).
//   - cargar_i held high reloads every cycle.
//  Error counter (4 bit):
//   - cargar_i & error_i & err_cnt<15 -> +1. Saturates at 15, never wraps.
//   - clr_cnt_i=1 -> 0; clear wins over a simultaneous increment.
//  Refresh:
//   - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
//   - On the wrap, digit_sel advances 0->1->2->3->0.
//  Digit content (internal active-high glyph):
//   - digit0 = hex(dato_r)
//   - digit1 = hex(sind_r)
//   - digit2 = 'E' (7'h79) if err_r, else '-' (7'h40)
//   - digit3 = hex(err_cnt)
//   - Hex glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  Outputs:
//   - Registered; value = f(state at previous edge), i.e. 1-cycle latency.
//   - While div_cnt < BLANK_CYCLES: anodes all off, segments all off.
//   - Otherwise: anodo bit[digit_sel] on, others off; segments = glyph of digit_sel.
//   - Polarity inversion applied last per SEG_ACTIVE_LOW / AN_ACTIVE_LOW.
//  Reset mid-scan: all state returns to reset values immediately.
//   - Scan restarts at digit0 with a blank slot.
// TESTING (bench uses REFRESH_DIV=8, BLANK_CYCLES=2, default polarities)
//  1. Reset, then release -> anodo_o=4'hF, siete_seg_o=7'h7F until blank ends.
//     Then anodo_o=4'hE, siete_seg_o=~7'h3F.
//  2. cargar_i pulse with dato=4'hA, sind=3'd5, err=1 -> over one full scan:
//     - digit0 ~7'h77
//     - digit1 ~7'h6D
//     - digit2 ~7'h79
//     - digit3 ~7'h06
//  3. 17 load pulses with error_i=1 -> digit3 shows ~7'h71 (15, saturated).
//     Then clr_cnt_i together with an error load -> digit3 shows ~7'h3F.
//  4. Per slot: exactly 2 blank cycles, then 6 lit cycles. Exactly one anode low when lit.
//     Digit order repeats 0,1,2,3 with period 32 cycles.
//  5. Assert rst_n_i mid-slot on digit2 -> outputs all-off in the same cycle (async).
//     After release, scan resumes at digit0 with a blank slot.

Source files
------------

// File: rtl/module_display_mux.sv
// Four-digit time-multiplexed seven-segment driver for the Hamming decoder.
// Shows data, syndrome, error flag and a saturating error count, with a blank interval at the start of each digit slot.
module module_display_mux #(
  parameter int unsigned REFRESH_DIV    = 27000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] dato_i,
  input  logic [2:0] sindrome_i,
  input  logic       error_i,
  input  logic       cargar_i,
  input  logic       clr_cnt_i,
  output logic [3:0] anodo_o,
  output logic [6:0] siete_seg_o
);

  localparam int unsigned     DIV_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [3:0]      AN_OFF    = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0]      SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [6:0]      GLYPH_E   = 7'h79;
  localparam logic [6:0]      GLYPH_DASH = 7'h40;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  digit_e           digit_sel;
  digit_e           digit_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic [3:0]       dato_r;
  logic [2:0]       sind_r;
  logic             err_r;
  logic [3:0]       err_cnt;
  logic [3:0]       an_raw;
  logic [6:0]       seg_raw;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt   <= '0;
      digit_sel <= DIG0;
    end else begin
      div_cnt   <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      digit_sel <= digit_nxt;
    end
  end

  always_comb begin
    digit_nxt = digit_sel;
    if (div_wrap) begin
      case (digit_sel)
        DIG0:    digit_nxt = DIG1;
        DIG1:    digit_nxt = DIG2;
        DIG2:    digit_nxt = DIG3;
        default: digit_nxt = DIG0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dato_r <= '0;
      sind_r <= '0;
      err_r  <= 1'b0;
    end else if (cargar_i) begin
      dato_r <= dato_i;
      sind_r <= sindrome_i;
      err_r  <= error_i;
    end
  end

  // Clear takes priority over a coincident increment; the count sticks at 15.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt <= '0;
    end else if (clr_cnt_i) begin
      err_cnt <= '0;
    end else if (cargar_i && error_i && (err_cnt != 4'hF)) begin
      err_cnt <= err_cnt + 4'd1;
    end
  end

  always_comb begin
    an_raw  = '0;
    seg_raw = '0;
    if (div_cnt >= BLANK_END) begin
      an_raw = 4'b0001 << digit_sel;
      case (digit_sel)
        DIG0:    seg_raw = hex_glyph(dato_r);
        DIG1:    seg_raw = hex_glyph({1'b0, sind_r});
        DIG2:    seg_raw = err_r ? GLYPH_E : GLYPH_DASH;
        default: seg_raw = hex_glyph(err_cnt);
      endcase
    end
  end

  // Polarity is folded in by XOR with the off pattern so reset and blank share one encoding.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      anodo_o     <= AN_OFF;
      siete_seg_o <= SEG_OFF;
    end else begin
      anodo_o     <= an_raw ^ AN_OFF;
      siete_seg_o <= seg_raw ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_module_display_mux.sv
// Scoreboard bench for module_display_mux: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the registered outputs.
module tb_module_display_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] dato;
  logic [2:0] sind;
  logic       err;
  logic       cargar;
  logic       clr_cnt;
  logic [3:0] anodo;
  logic [6:0] seg;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   drain_req = 1'b0;
  bit   drain_done = 1'b0;

  module_display_mux #(
    .REFRESH_DIV   (8),
    .BLANK_CYCLES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .dato_i     (dato),
    .sindrome_i (sind),
    .error_i    (err),
    .cargar_i   (cargar),
    .clr_cnt_i  (clr_cnt),
    .anodo_o    (anodo),
    .siete_seg_o(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_off(input int c);
    exp_t e;
    e.cyc = c;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    q.push_back(e);
  endtask

  // Output seen k cycles after release: slot position (k-1)%8, digit ((k-1)/8)%4.
  task automatic push_scan(input int b, input int k0, input int k1,
                           input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3);
    logic [6:0] g[4];
    logic [3:0] an_tbl[4];
    exp_t e;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    an_tbl[0] = 4'hE; an_tbl[1] = 4'hD; an_tbl[2] = 4'hB; an_tbl[3] = 4'h7;
    for (int k = k0; k <= k1; k++) begin
      int p;
      int d;
      p = (k - 1) % 8;
      d = ((k - 1) / 8) % 4;
      e.cyc = b + k;
      if (p < 2) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end else begin
        e.an  = an_tbl[d];
        e.seg = ~g[d];
      end
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sched: expectation for cycle %0d reached at cycle %0d", e.cyc, cyc);
      end else if (anodo !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL scan cyc=%0d: anodo=%h seg=%h, expected anodo=%h seg=%h",
                 cyc, anodo, seg, e.an, e.seg);
      end
    end
    if (drain_req && !drain_done) begin
      drain_done = 1'b1;
      n_checks++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
    end
  end

  initial begin
    int base;
    int base2;
    int guard;
    rst_n   = 1'b0;
    dato    = '0;
    sind    = '0;
    err     = 1'b0;
    cargar  = 1'b0;
    clr_cnt = 1'b0;
    repeat (3) tick();

    // Reset contents: 0, 0, '-', 0
    base = cyc;
    push_off(base);
    push_scan(base, 1, 32, 7'h3F, 7'h3F, 7'h40, 7'h3F);
    rst_n = 1'b1;

    wait_cyc(base + 32);
    dato   = 4'hA;
    sind   = 3'd5;
    err    = 1'b1;
    cargar = 1'b1;
    push_scan(base, 33, 64, 7'h77, 7'h6D, 7'h79, 7'h06);
    tick();
    cargar = 1'b0;

    // 17 error loads on top of the 1 already counted: must stick at F
    wait_cyc(base + 64);
    push_scan(base, 97, 128, 7'h77, 7'h6D, 7'h79, 7'h71);
    for (int i = 0; i < 17; i++) begin
      cargar = 1'b1;
      tick();
      cargar = 1'b0;
      tick();
    end

    wait_cyc(base + 128);
    cargar  = 1'b1;
    clr_cnt = 1'b1;
    push_scan(base, 129, 179, 7'h77, 7'h6D, 7'h79, 7'h3F);
    tick();
    cargar  = 1'b0;
    clr_cnt = 1'b0;

    // Reset lands mid digit2 slot, just after an edge: outputs must go off before the next edge
    wait_cyc(base + 180);
    push_off(base + 180);
    push_off(base + 181);
    push_off(base + 182);
    rst_n = 1'b0;
    tick();
    tick();
    base2 = cyc;
    push_scan(base2, 1, 32, 7'h3F, 7'h3F, 7'h40, 7'h3F);
    rst_n = 1'b1;

    wait_cyc(base2 + 32);
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    drain_req = 1'b1;
    guard = 0;
    while (!drain_done && guard < 10) begin
      tick();
      guard++;
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
